// File: rtl/ram_write_sequencer_if.sv
// ram_write_sequencer_if: pixel stream in, per-block RAM write strobes out
interface ram_write_sequencer_if;
  logic        in_valid;
  logic        in_sof;
  logic [23:0] in_data;
  logic [23:0] ram_data;
  logic [3:0]  block_number;
  logic [6:0]  pixel_number;
  logic        block_write_enable;
  logic [7:0]  wslice_cnt;
  logic        SOF;
  logic        EOS;
  modport master (
    output in_valid, in_sof, in_data,
    input  ram_data, block_number, pixel_number, block_write_enable, wslice_cnt, SOF, EOS
  );
  modport slave (
    input  in_valid, in_sof, in_data,
    output ram_data, block_number, pixel_number, block_write_enable, wslice_cnt, SOF, EOS
  );
endinterface

// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer: maps a flat pixel stream onto block/pixel/slice write strobes
module ram_write_sequencer #(
  parameter int BLOCKS = 15,
  parameter int PIXELS = 80,
  parameter int SLICES = 128
) (
  input  logic                        clk,
  input  logic                        nrst,
  ram_write_sequencer_if.slave        wr,
  input  logic                        rslice_step,
  input  logic                        rslice_clr,
  input  logic                        err_clr,
  output logic [7:0]                  rslice_cnt,
  output logic                        err_resync,
  output logic                        err_overrun
);
  localparam logic [6:0] P_LAST = 7'(PIXELS - 1);
  localparam logic [3:0] B_LAST = 4'(BLOCKS - 1);
  localparam logic [7:0] S_LAST = 8'(SLICES - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t     state;
  logic [6:0] pix, wp;
  logic [3:0] blk, wb;
  logic [7:0] slc, ws;
  logic       restart, accept, overrun, resync, eos, frame_end;
  // wp/wb/ws is where the current pixel lands; an in_sof pixel always lands at 0/0/0
  always_comb begin
    restart   = wr.in_valid & wr.in_sof;
    accept    = wr.in_valid & (wr.in_sof | state == STREAM);
    overrun   = wr.in_valid & ~wr.in_sof & state != STREAM;
    resync    = restart & state == STREAM & (pix != '0 | blk != '0 | slc != '0);
    wp        = restart ? '0 : pix;
    wb        = restart ? '0 : blk;
    ws        = restart ? '0 : slc;
    eos       = wp == P_LAST & wb == B_LAST;
    frame_end = eos & ws == S_LAST;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state                 <= IDLE;
      pix                   <= '0;
      blk                   <= '0;
      slc                   <= '0;
      wr.ram_data           <= '0;
      wr.block_number       <= '0;
      wr.pixel_number       <= '0;
      wr.wslice_cnt         <= '0;
      wr.block_write_enable <= 1'b0;
      wr.SOF                <= 1'b0;
      wr.EOS                <= 1'b0;
      err_resync            <= 1'b0;
      err_overrun           <= 1'b0;
      rslice_cnt            <= '0;
    end else begin
      wr.block_write_enable <= accept;
      wr.SOF                <= restart;
      wr.EOS                <= accept & eos;
      if (accept) begin
        wr.ram_data     <= wr.in_data;
        wr.block_number <= wb;
        wr.pixel_number <= wp;
        wr.wslice_cnt   <= ws;
        pix             <= wp == P_LAST ? '0 : wp + 7'd1;
        blk             <= wp == P_LAST ? (wb == B_LAST ? '0 : wb + 4'd1) : wb;
        slc             <= eos ? (frame_end ? '0 : ws + 8'd1) : ws;
        state           <= frame_end ? DONE : STREAM;
      end
      err_overrun <= overrun | (err_overrun & ~err_clr);
      err_resync  <= resync | (err_resync & ~err_clr);
      rslice_cnt  <= rslice_clr ? '0 : rslice_step ? (rslice_cnt == S_LAST ? '0 : rslice_cnt + 8'd1) : rslice_cnt;
    end
  end
endmodule

// File: tb/tb_ram_write_sequencer.sv
// tb_ram_write_sequencer: random pixel stream against a flat-index frame model with a write scoreboard
module tb_ram_write_sequencer;
  localparam int P = 4, B = 3, S = 2, N = P * B * S, SR = 128;
  logic clk = 0, nrst = 0, rslice_step = 0, rslice_clr = 0, err_clr = 0;
  logic [7:0] rs_a, rs_b;
  logic er_a, eo_a, er_b, eo_b;
  ram_write_sequencer_if wr_a();
  ram_write_sequencer_if wr_b();
  assign wr_b.in_valid = 1'b0;
  assign wr_b.in_sof   = 1'b0;
  assign wr_b.in_data  = '0;
  ram_write_sequencer #(.BLOCKS(B), .PIXELS(P), .SLICES(S)) dut (
    .clk(clk), .nrst(nrst), .wr(wr_a), .rslice_step(rslice_step), .rslice_clr(rslice_clr),
    .err_clr(err_clr), .rslice_cnt(rs_a), .err_resync(er_a), .err_overrun(eo_a));
  ram_write_sequencer dut_r (
    .clk(clk), .nrst(nrst), .wr(wr_b), .rslice_step(rslice_step), .rslice_clr(rslice_clr),
    .err_clr(err_clr), .rslice_cnt(rs_b), .err_resync(er_b), .err_overrun(eo_b));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  b;
    logic [6:0]  p;
    logic [7:0]  s;
    logic        sof;
    logic        eos;
  } wr_t;
  wr_t q[$];
  wr_t last, mon_e;
  int  n_chk = 0, n_fail = 0;
  bit  open = 0, exp_o = 0, exp_r = 0;
  int  k = 0, rc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t expect_at(input int idx, input logic [23:0] d, input bit sof);
    wr_t e;
    e.d   = d;
    e.b   = 4'((idx / P) % B);
    e.p   = 7'(idx % P);
    e.s   = 8'(idx / (P * B));
    e.sof = sof;
    e.eos = (idx % (P * B)) == P * B - 1;
    return e;
  endfunction

  task automatic cyc(input bit v, input bit s = 0, input bit c = 0);
    logic [23:0] d;
    bit so, sr;
    d = 24'($urandom);
    @(posedge clk); #1;
    wr_a.in_valid = v;
    wr_a.in_sof   = s;
    wr_a.in_data  = d;
    err_clr       = c;
    so = v && !s && !open;
    sr = v && s && open && k != 0;
    if (v && s) begin open = 1; k = 0; end
    if (v && open) begin
      q.push_back(expect_at(k, d, s));
      k++;
      if (k == N) begin open = 0; k = 0; end
    end
    exp_o = so | (exp_o & !c);
    exp_r = sr | (exp_r & !c);
  endtask

  task automatic rs(input bit step, input bit clr);
    @(posedge clk); #1;
    rslice_step = step;
    rslice_clr  = clr;
    rc = clr ? 0 : rc + int'(step);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_overrun"}, eo_a, exp_o);
    chk({tag, "_resync"}, er_a, exp_r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we_sof_eos"}, {wr_a.block_write_enable, wr_a.SOF, wr_a.EOS}, 0);
    chk({tag, "_data"}, wr_a.ram_data, 0);
    chk({tag, "_addr"}, {wr_a.block_number, wr_a.pixel_number, wr_a.wslice_cnt}, 0);
    chk({tag, "_rslice"}, {rs_a, rs_b}, 0);
    chk({tag, "_errs"}, {er_a, eo_a, er_b, eo_b}, 0);
  endtask

  task automatic do_reset(input int cycles);
    cyc(0); cyc(0);
    @(posedge clk); #1;
    nrst = 0;
    wr_a.in_valid = 0;
    rslice_step = 0;
    rslice_clr = 0;
    err_clr = 0;
    open = 0; k = 0; exp_o = 0; exp_r = 0; rc = 0;
    repeat (cycles) @(posedge clk);
    #1 nrst = 1;
  endtask

  // every cycle either consumes one expected write or confirms the address outputs held
  always @(negedge clk) begin
    if (!nrst) last = '0;
    else if (wr_a.block_write_enable === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("write", {wr_a.ram_data, wr_a.block_number, wr_a.pixel_number, wr_a.wslice_cnt, wr_a.SOF, wr_a.EOS}, mon_e);
        last = mon_e;
      end
    end else
      chk("hold", {wr_a.block_write_enable, wr_a.block_number, wr_a.pixel_number, wr_a.wslice_cnt, wr_a.SOF, wr_a.EOS},
          {1'b0, last.b, last.p, last.s, 2'b00});
  end

  initial begin
    wr_a.in_valid = 0;
    wr_a.in_sof = 0;
    wr_a.in_data = '0;
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    chk_zero("reset");
    for (int i = 0; i < N; i++) cyc(1, i == 0);
    cyc(0); cyc(0);
    chk("frame1_drained", q.size(), 0);
    for (int i = 0; i < N; i++) begin cyc(1, i == 0); cyc(0); end
    cyc(0);
    chk("frame2_drained", q.size(), 0);
    cyc(1); cyc(0); chk_err("done_ovr");
    cyc(0, 0, 1); cyc(0); chk_err("done_clr");
    do_reset(1);
    cyc(1); cyc(1); cyc(0); chk_err("idle_ovr");
    cyc(1, 0, 1); cyc(0); chk_err("set_wins");
    cyc(0, 0, 1); cyc(0); chk_err("idle_clr");
    cyc(0, 1); cyc(0); chk_err("sof_no_valid");
    for (int i = 0; i < 2 * N; i++) cyc(1, i % N == 0);
    cyc(0); chk_err("back_to_back");
    cyc(1, 1);
    repeat (20) cyc(1);
    cyc(1, 1);
    cyc(0); chk_err("resync");
    repeat (N - 1) cyc(1);
    cyc(0); cyc(0, 0, 1); cyc(0); chk_err("resync_clr");
    cyc(1, 1);
    repeat (5) cyc(1);
    do_reset(2);
    chk_zero("mid_reset");
    cyc(1, 1); cyc(0);
    repeat (N - 1) cyc(1);
    cyc(0); cyc(0); chk_err("after_reset");
    repeat (130) rs(1, 0);
    rs(0, 0);
    chk("rslice_small", rs_a, 8'(rc % S));
    chk("rslice_big", rs_b, 8'(rc % SR));
    rs(1, 1); rs(0, 0);
    chk("rslice_clr", {rs_a, rs_b}, 0);
    repeat (5) rs(1, 0);
    rs(0, 0);
    chk("rslice_5", {rs_a, rs_b}, {8'(rc % S), 8'(rc % SR)});
    cyc(1, 1);
    for (int i = 0; i < 8; i++) begin
      repeat (60) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 70) == 0, $urandom_range(0, 40) == 0);
      cyc(0); chk_err("random");
    end
    cyc(0); cyc(0);
    chk("final_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
